// File: rtl/vs_dc_hex_ascii_pkg.sv
// Shared types, ASCII base codes and the nibble-to-character mapping used by
// the hex/ASCII converter and the UART TX formatter.
package vs_dc_hex_ascii_pkg;

    typedef logic [3:0] nibble_t;
    typedef logic [7:0] ascii_t;

    localparam ascii_t ASCII_ZERO    = 8'h30;
    localparam ascii_t ASCII_UPPER_A = 8'h41;
    localparam ascii_t ASCII_LOWER_A = 8'h61;

    // Digits 0-9 map onto '0'..'9'; 10-15 map onto 'A'..'F' or 'a'..'f'.
    // The letter offset is taken in 4 bits so it never borrows into the
    // upper byte; the result is then zero-extended and added in 8 bits.
    function automatic ascii_t hex_to_ascii(input nibble_t nibble, input logic lower);
        nibble_t letter_ofs;
        ascii_t  result;
        letter_ofs = nibble - 4'd10;
        if (nibble > 4'd9) begin
            result = (lower ? ASCII_LOWER_A : ASCII_UPPER_A) + {4'h0, letter_ofs};
        end else begin
            result = ASCII_ZERO + {4'h0, nibble};
        end
        return result;
    endfunction

endpackage

// File: rtl/vs_dc_hex_ascii_if.sv
// Character conversion port: the formatter (master) offers a nibble and case
// request, the converter (slave) answers with the ASCII code and a valid flag.
interface vs_dc_hex_ascii_if;
    import vs_dc_hex_ascii_pkg::*;

    logic    en;
    nibble_t hex;
    logic    lower;
    ascii_t  ascii;
    logic    valid;

    modport master (
        output en,
        output hex,
        output lower,
        input  ascii,
        input  valid
    );

    modport slave (
        input  en,
        input  hex,
        input  lower,
        output ascii,
        output valid
    );

endinterface

// File: rtl/vs_dc_hex_ascii_lut.sv
// Pure combinational nibble -> ASCII lookup; no state, reusable by any
// formatter that needs printable hex digits.
module vs_dc_hex_ascii_lut
    import vs_dc_hex_ascii_pkg::*;
(
    input  nibble_t nibble,
    input  logic    lower,
    output ascii_t  ascii
);

    // Map the nibble through the shared conversion function.
    always_comb begin
        ascii = hex_to_ascii(nibble, lower);
    end

endmodule

// File: rtl/vs_dc_hex_ascii.sv
// Hex nibble to ASCII converter for the UART TX path. REGISTERED=1 gives a
// one-cycle registered result with a valid strobe; REGISTERED=0 is a pure
// combinational bypass where valid simply follows en.
module vs_dc_hex_ascii
    import vs_dc_hex_ascii_pkg::*;
#(
    parameter bit REGISTERED    = 1'b1,
    parameter bit LOWER_DEFAULT = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    vs_dc_hex_ascii_if.slave     bus
);

    ascii_t lut_ascii;
    logic   case_lower;

    // A tied-low lower input selects the build-time default case; driving it
    // high flips to the other case.
    assign case_lower = bus.lower ^ LOWER_DEFAULT;

    vs_dc_hex_ascii_lut u_lut (
        .nibble (bus.hex),
        .lower  (case_lower),
        .ascii  (lut_ascii)
    );

    generate
        if (REGISTERED) begin : g_registered
            ascii_t ascii_reg;
            logic   valid_reg;

            // Capture the converted character on enabled edges; valid marks
            // exactly the cycle after each accepted nibble.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ascii_reg <= 8'h00;
                    valid_reg <= 1'b0;
                end else begin
                    valid_reg <= bus.en;
                    if (bus.en) begin
                        ascii_reg <= lut_ascii;
                    end
                end
            end

            assign bus.ascii = ascii_reg;
            assign bus.valid = valid_reg;
        end else begin : g_bypass
            assign bus.ascii = lut_ascii;
            assign bus.valid = bus.en;
        end
    endgenerate

endmodule

// File: tb/tb_vs_dc_hex_ascii.sv
// Bench for vs_dc_hex_ascii: a registered/uppercase instance, a combinational
// bypass instance and a registered LOWER_DEFAULT=1 instance. Expected codes
// come from a character table and flow through per-instance queues.
module tb_vs_dc_hex_ascii;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic [7:0] q_reg[$];
    logic [7:0] q_ld[$];
    logic [7:0] exp_c;
    logic [7:0] last_reg;

    vs_dc_hex_ascii_if bus_reg ();
    vs_dc_hex_ascii_if bus_comb ();
    vs_dc_hex_ascii_if bus_ld ();

    vs_dc_hex_ascii #(.REGISTERED(1'b1), .LOWER_DEFAULT(1'b0)) dut_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_reg.slave)
    );

    vs_dc_hex_ascii #(.REGISTERED(1'b0), .LOWER_DEFAULT(1'b0)) dut_comb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_comb.slave)
    );

    vs_dc_hex_ascii #(.REGISTERED(1'b1), .LOWER_DEFAULT(1'b1)) dut_ld (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_ld.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Character table: index the printable string by the nibble value.
    function automatic logic [7:0] ref_char(input logic [3:0] h, input logic lc);
        string up;
        string lo;
        up = "0123456789ABCDEF";
        lo = "0123456789abcdef";
        return lc ? lo[int'(h)] : up[int'(h)];
    endfunction

    // Drive the registered instance and queue the expected character.
    task automatic drive_reg(input logic e, input logic [3:0] h, input logic l);
        bus_reg.en    = e;
        bus_reg.hex   = h;
        bus_reg.lower = l;
        if (e) q_reg.push_back(ref_char(h, l));
    endtask

    // Drive the LOWER_DEFAULT=1 instance; its effective case is inverted.
    task automatic drive_ld(input logic e, input logic [3:0] h, input logic l);
        bus_ld.en    = e;
        bus_ld.hex   = h;
        bus_ld.lower = l;
        if (e) q_ld.push_back(ref_char(h, ~l));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_reg(1'b0, 4'h0, 1'b0);
        drive_ld(1'b0, 4'h0, 1'b0);
        bus_comb.en = 1'b0; bus_comb.hex = 4'h0; bus_comb.lower = 1'b0;
        tick();
        tick();
        total++;
        if (bus_reg.ascii !== 8'h00 || bus_reg.valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_reg ascii=%h valid=%b required ascii=00 valid=0", bus_reg.ascii, bus_reg.valid);
        end
        total++;
        if (bus_ld.ascii !== 8'h00 || bus_ld.valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_ld ascii=%h valid=%b required ascii=00 valid=0", bus_ld.ascii, bus_ld.valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++;
        if (bus_reg.ascii !== 8'h00 || bus_reg.valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold ascii=%h valid=%b required ascii=00 valid=0", bus_reg.ascii, bus_reg.valid);
        end
        $display("reset: ascii=%h valid=%b", bus_reg.ascii, bus_reg.valid);
    endtask

    task automatic test_sweep(input logic l);
        logic [7:0] e;
        for (int i = 0; i < 16; i++) begin
            drive_reg(1'b1, 4'(i), l);
            tick();
            total++;
            if (q_reg.size() == 0) begin
                bad++;
                $display("FAIL sweep_queue_empty lower=%b hex=%h", l, 4'(i));
            end else begin
                e = q_reg.pop_front();
                if (bus_reg.ascii !== e || bus_reg.valid !== 1'b1) begin
                    bad++;
                    $display("FAIL sweep lower=%b hex=%h ascii=%h valid=%b required ascii=%h valid=1",
                             l, 4'(i), bus_reg.ascii, bus_reg.valid, e);
                end
                $display("sweep lower=%b hex=%h ascii=%h valid=%b", l, 4'(i), bus_reg.ascii, bus_reg.valid);
            end
        end
        last_reg = bus_reg.ascii;
    endtask

    task automatic test_en_gating();
        logic [7:0] e;
        drive_reg(1'b1, 4'h7, 1'b0);
        tick();
        total++;
        e = (q_reg.size() != 0) ? q_reg.pop_front() : 8'hxx;
        if (bus_reg.ascii !== e || e !== 8'h37 || bus_reg.valid !== 1'b1) begin
            bad++;
            $display("FAIL gate_load ascii=%h valid=%b required ascii=37 valid=1", bus_reg.ascii, bus_reg.valid);
        end
        last_reg = e;
        drive_reg(1'b0, 4'hC, 1'b1);
        tick();
        total++;
        if (bus_reg.ascii !== last_reg || bus_reg.valid !== 1'b0 || q_reg.size() != 0) begin
            bad++;
            $display("FAIL gate_hold ascii=%h valid=%b required ascii=%h valid=0", bus_reg.ascii, bus_reg.valid, last_reg);
        end
        $display("en_gating: ascii=%h valid=%b", bus_reg.ascii, bus_reg.valid);
    endtask

    task automatic test_async_reset();
        logic [7:0] e;
        drive_reg(1'b1, 4'hF, 1'b0);
        tick();
        total++;
        e = (q_reg.size() != 0) ? q_reg.pop_front() : 8'hxx;
        if (bus_reg.ascii !== 8'h46 || e !== 8'h46) begin
            bad++;
            $display("FAIL areset_pre ascii=%h required 46", bus_reg.ascii);
        end
        drive_reg(1'b0, 4'hF, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus_reg.ascii !== 8'h00 || bus_reg.valid !== 1'b0) begin
            bad++;
            $display("FAIL areset_now ascii=%h valid=%b required ascii=00 valid=0", bus_reg.ascii, bus_reg.valid);
        end
        q_reg.delete();
        @(negedge clk);
        rst_n = 1'b1;
        drive_reg(1'b1, 4'h0, 1'b0);
        tick();
        total++;
        e = (q_reg.size() != 0) ? q_reg.pop_front() : 8'hxx;
        if (bus_reg.ascii !== e || e !== 8'h30 || bus_reg.valid !== 1'b1) begin
            bad++;
            $display("FAIL areset_after ascii=%h valid=%b required ascii=30 valid=1", bus_reg.ascii, bus_reg.valid);
        end
        drive_reg(1'b0, 4'h0, 1'b0);
        $display("async_reset: ascii=%h valid=%b", bus_reg.ascii, bus_reg.valid);
    endtask

    task automatic test_comb();
        for (int i = 0; i < 16; i++) begin
            bus_comb.hex   = 4'(i);
            bus_comb.en    = (i % 3) != 0;
            bus_comb.lower = (i == 13);
            exp_c = ref_char(4'(i), bus_comb.lower);
            #1;
            total++;
            if (bus_comb.ascii !== exp_c || bus_comb.valid !== bus_comb.en) begin
                bad++;
                $display("FAIL comb hex=%h ascii=%h valid=%b required ascii=%h valid=%b",
                         4'(i), bus_comb.ascii, bus_comb.valid, exp_c, bus_comb.en);
            end
            $display("comb hex=%h en=%b ascii=%h valid=%b", 4'(i), bus_comb.en, bus_comb.ascii, bus_comb.valid);
            #19;
        end
    endtask

    task automatic test_lower_default();
        logic [7:0] e;
        logic       l_seq [3];
        logic [3:0] h_seq [3];
        l_seq[0] = 1'b1; h_seq[0] = 4'hB;
        l_seq[1] = 1'b0; h_seq[1] = 4'hB;
        l_seq[2] = 1'b0; h_seq[2] = 4'h5;
        for (int i = 0; i < 3; i++) begin
            drive_ld(1'b1, h_seq[i], l_seq[i]);
            tick();
            total++;
            if (q_ld.size() == 0) begin
                bad++;
                $display("FAIL lower_default_queue_empty hex=%h", h_seq[i]);
            end else begin
                e = q_ld.pop_front();
                if (bus_ld.ascii !== e || bus_ld.valid !== 1'b1) begin
                    bad++;
                    $display("FAIL lower_default hex=%h lower=%b ascii=%h valid=%b required ascii=%h valid=1",
                             h_seq[i], l_seq[i], bus_ld.ascii, bus_ld.valid, e);
                end
            end
            $display("lower_default hex=%h lower=%b ascii=%h", h_seq[i], l_seq[i], bus_ld.ascii);
        end
        drive_ld(1'b0, 4'h0, 1'b0);
        tick();
        total++;
        if (bus_ld.valid !== 1'b0) begin
            bad++;
            $display("FAIL lower_default_idle valid=%b required 0", bus_ld.valid);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_sweep(1'b0);
        test_sweep(1'b1);
        test_en_gating();
        test_async_reset();
        test_comb();
        test_lower_default();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global bound so a stuck run still terminates.
    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
